clk_switch_ctrl: RTL and testbench



---
 rtl/clk_sw_pkg.sv | 20 ++
 rtl/clk_sw_timer.sv | 42 ++++
 rtl/clk_switch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_sw_pkg.sv
// clk_sw_pkg: shared types and helpers for the clock-switch sequencer.
//   csw_state_e  : sequencer states (idle / settle window running)
//   CSW_SEL_CLK0 : select value that picks clk0
//   CSW_SEL_CLK1 : select value that picks clk1
//   csw_cnt_w()  : counter width needed to hold values 0 .. n-1 (at least 1 bit)
package clk_sw_pkg;

    typedef enum logic [0:0] {
        CSW_IDLE   = 1'b0,
        CSW_SETTLE = 1'b1
    } csw_state_e;

    localparam logic CSW_SEL_CLK0 = 1'b0;
    localparam logic CSW_SEL_CLK1 = 1'b1;

    function automatic int unsigned csw_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_sw_timer.sv
// clk_sw_timer: loadable down-counter that stops at zero.
// Ports:
//   clk      in   reference clock (rising edge)
//   rst_n    in   synchronous active-low reset, clears the count
//   load     in   load load_val this cycle (has priority over en)
//   load_val in   value to load
//   en       in   decrement while the count is nonzero
//   zero     out  count equals zero
module clk_sw_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequencer for the glitch-free two-input clock switch.
// Accepts clock-select requests, checks the target clock is present, drives the mux
// select from a flop and holds it for SETTLE_CYC cycles before committing cur_sel.
// Optional automatic failover is enabled by defining CLK_SW_FAILOVER_EN.
// Ports:
//   clk        in   always-on reference clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   switch request
//   req_sel    in   requested clock (0 = clk0, 1 = clk1)
//   req_ready  out  request accepted when req_valid & req_ready (combinational)
//   clk0_ok    in   clk0 present (already synchronised)
//   clk1_ok    in   clk1 present (already synchronised)
//   select     out  mux select, straight from a flop
//   cur_sel    out  committed clock, updated when the settle window ends
//   busy       out  settle window running
//   done       out  pulse: request or failover completed
//   err        out  pulse: request rejected, target clock not ok
//   fail_evt   out  pulse: failover switch started (0 without CLK_SW_FAILOVER_EN)
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned FAIL_CYC   = 4,
    parameter logic        RST_SEL    = CSW_SEL_CLK0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk0_ok,
    input  logic clk1_ok,
    output logic select,
    output logic cur_sel,
    output logic busy,
    output logic done,
    output logic err,
    output logic fail_evt
);

    localparam int unsigned    SW          = csw_cnt_w(SETTLE_CYC);
    localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYC - 1);

    csw_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       cur_q, cur_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       fev_q, fev_d;
    logic       tmr_load;
    logic       tmr_zero;
    logic       ok_cur;
    logic       ok_target;
    logic       fail_trip;

    assign ok_cur    = cur_q   ? clk1_ok : clk0_ok;
    assign ok_target = req_sel ? clk1_ok : clk0_ok;

`ifdef CLK_SW_FAILOVER_EN
    localparam int unsigned   FW       = csw_cnt_w(FAIL_CYC);
    localparam logic [FW-1:0] FAIL_MAX = FW'(FAIL_CYC - 1);

    logic          ok_other;
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;

    assign ok_other = cur_q ? clk0_ok : clk1_ok;

    // Counts consecutive idle cycles with the active clock missing; saturates.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if ((state_q != CSW_IDLE) || ok_cur) begin
            fail_cnt_d = '0;
        end else if (fail_cnt_q != FAIL_MAX) begin
            fail_cnt_d = fail_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // With both clocks gone the counter sits saturated and fires once the other returns.
    assign fail_trip = (state_q == CSW_IDLE) && (fail_cnt_q == FAIL_MAX) && !ok_cur && ok_other;
`else
    assign fail_trip = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cur_d    = cur_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fev_d    = 1'b0;
        tmr_load = 1'b0;
        case (state_q)
            CSW_IDLE: begin
                // Failover wins over a simultaneous request, which stays pending.
                if (fail_trip) begin
                    sel_d    = ~cur_q;
                    fev_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = CSW_SETTLE;
                end else if (req_valid) begin
                    if (req_sel == cur_q) begin
                        done_d = 1'b1;
                    end else if (!ok_target) begin
                        err_d = 1'b1;
                    end else begin
                        sel_d    = req_sel;
                        tmr_load = 1'b1;
                        state_d  = CSW_SETTLE;
                    end
                end
            end
            CSW_SETTLE: begin
                if (tmr_zero) begin
                    cur_d   = sel_q;
                    done_d  = 1'b1;
                    state_d = CSW_IDLE;
                end
            end
            default: state_d = CSW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CSW_IDLE;
            sel_q   <= RST_SEL;
            cur_q   <= RST_SEL;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
        end
    end

    clk_sw_timer #(
        .WIDTH(SW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .en       (state_q == CSW_SETTLE),
        .zero     (tmr_zero)
    );

    assign req_ready = (state_q == CSW_IDLE) && !fail_trip;
    assign select    = sel_q;
    assign cur_sel   = cur_q;
    assign busy      = (state_q == CSW_SETTLE);
    assign done      = done_q;
    assign err       = err_q;
    assign fail_evt  = fev_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed plus randomized checks of clk_switch_ctrl against a
// timestamp-based reference model. Failover checks are active when CLK_SW_FAILOVER_EN
// is defined for both bench and design.
module tb_clk_switch_ctrl;

    localparam int   SETTLE_CYC = 16;
    localparam int   FAIL_CYC   = 4;
    localparam logic RST_SEL    = 1'b0;

    logic clk = 1'b0;
    logic rst_n, req_valid, req_sel, req_ready, clk0_ok, clk1_ok;
    logic select, cur_sel, busy, done, err, fail_evt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: committed/selected clock, and the edge number at which a
    // running switch commits.
    logic m_sel, m_cur, m_settling, m_done, m_err, m_fev;
    int   m_edge, m_end_edge, m_low_run;

    always #5 clk = ~clk;

    clk_switch_ctrl #(
        .SETTLE_CYC (SETTLE_CYC),
        .FAIL_CYC   (FAIL_CYC),
        .RST_SEL    (RST_SEL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .clk0_ok   (clk0_ok),
        .clk1_ok   (clk1_ok),
        .select    (select),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fail_evt  (fail_evt)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, m_edge);
        end
    endtask

    task automatic model_reset();
        m_sel      = RST_SEL;
        m_cur      = RST_SEL;
        m_settling = 1'b0;
        m_done     = 1'b0;
        m_err      = 1'b0;
        m_fev      = 1'b0;
        m_end_edge = -1;
        m_low_run  = 0;
    endtask

    function automatic logic m_trip(input logic o0, input logic o1);
`ifdef CLK_SW_FAILOVER_EN
        logic okc, oko;
        okc = m_cur ? o1 : o0;
        oko = m_cur ? o0 : o1;
        return !m_settling && (m_low_run >= FAIL_CYC - 1) && !okc && oko;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_ready(input logic o0, input logic o1);
        return !m_settling && !m_trip(o0, o1);
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic v, input logic s, input logic o0, input logic o1,
                              input logic rn);
        logic trip, okc, okt;
        m_edge++;
        if (!rn) begin
            model_reset();
            return;
        end
        trip   = m_trip(o0, o1);
        okc    = m_cur ? o1 : o0;
        okt    = s ? o1 : o0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_fev  = 1'b0;
        if (m_settling) begin
            m_low_run = 0;
            if (m_edge == m_end_edge) begin
                m_cur      = m_sel;
                m_settling = 1'b0;
                m_done     = 1'b1;
            end
        end else begin
            m_low_run = okc ? 0 : ((m_low_run + 1 > FAIL_CYC - 1) ? FAIL_CYC - 1 : m_low_run + 1);
            if (trip) begin
                m_sel      = !m_cur;
                m_settling = 1'b1;
                m_end_edge = m_edge + SETTLE_CYC;
                m_fev      = 1'b1;
            end else if (v) begin
                if (s == m_cur) begin
                    m_done = 1'b1;
                end else if (!okt) begin
                    m_err = 1'b1;
                end else begin
                    m_sel      = s;
                    m_settling = 1'b1;
                    m_end_edge = m_edge + SETTLE_CYC;
                end
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then cross the rising edge.
    task automatic step(input logic v, input logic s, input logic o0, input logic o1,
                        input logic rn);
        req_valid = v;
        req_sel   = s;
        clk0_ok   = o0;
        clk1_ok   = o1;
        rst_n     = rn;
        #1;
        check_eq("req_ready", req_ready, m_ready(o0, o1));
        check_eq("select",    select,    m_sel);
        check_eq("cur_sel",   cur_sel,   m_cur);
        check_eq("busy",      busy,      m_settling);
        check_eq("done",      done,      m_done);
        check_eq("err",       err,       m_err);
        check_eq("fail_evt",  fail_evt,  m_fev);
        model_edge(v, s, o0, o1, rn);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // Hold a request until the model says it is accepted, bounded.
    task automatic send(input logic s, input logic o0, input logic o1);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = m_ready(o0, o1);
            step(1'b1, s, o0, o1, 1'b1);
        end
        check_eq("send_accepted", acc, 1'b1);
    endtask

    initial begin
        logic pend, psel, ok0, ok1, rn, acc;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        clk0_ok   = 1'b1;
        clk1_ok   = 1'b1;
        rst_n     = 1'b0;
        m_edge    = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        idle(1);                                   // reset values
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);        // clk1 missing -> err
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        send(1'b1, 1'b1, 1'b1);                    // full switch to clk1
        idle(SETTLE_CYC + 2);
        send(1'b1, 1'b1, 1'b1);                    // same target -> done only
        idle(2);
        send(1'b0, 1'b1, 1'b1);                    // back-to-back switches
        send(1'b1, 1'b1, 1'b1);
        idle(SETTLE_CYC + 2);
        send(1'b0, 1'b1, 1'b1);                    // reset in the middle of settle
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

`ifdef CLK_SW_FAILOVER_EN
        for (int i = 0; i < FAIL_CYC - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        for (int i = 0; i < FAIL_CYC - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);        // trip cycle with a competing request
        for (int i = 0; i < SETTLE_CYC + 2; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);        // other clock returns -> switch
        idle(SETTLE_CYC + 2);
`endif

        pend = 1'b0;
        psel = 1'b0;
        ok0  = 1'b1;
        ok1  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && ($urandom_range(0, 3) == 0)) begin
                pend = 1'b1;
                psel = 1'($urandom_range(0, 1));
            end
            if (ok0) ok0 = ($urandom_range(0, 29) != 0);
            else     ok0 = ($urandom_range(0, 4) == 0);
            if (ok1) ok1 = ($urandom_range(0, 29) != 0);
            else     ok1 = ($urandom_range(0, 4) == 0);
            rn  = ($urandom_range(0, 299) != 0);
            acc = pend && rn && m_ready(ok0, ok1);
            step(pend, pend ? psel : 1'($urandom_range(0, 1)), ok0, ok1, rn);
            if (acc || !rn) pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
